// File: rtl/mem_responder.sv
// Word-addressed RAM behind a valid/ready request/response port, with a fixed
// number of wait states between request acceptance and response.

module mem_responder_lane #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            accept, addr_err, wr_en;
    logic [AW-1:0]   idx;
    logic [3:0][7:0] rd_word;

    assign accept   = req_valid && req_ready;
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign idx      = req_addr[AW+1:2];
    assign wr_en    = accept && req_we && !addr_err;

    // One byte-wide RAM per lane so byte enables map to independent write strobes.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        mem_responder_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
            .clk   (clk),
            .we    (wr_en && req_be[i]),
            .idx   (idx),
            .wdata (req_wdata[8*i +: 8]),
            .rdata (rd_word[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    // Response is captured at acceptance, so request fields are free to change afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            cnt       <= CNT_LOAD;
            rsp_err   <= addr_err;
            rsp_rdata <= (req_we || addr_err) ? 32'd0 : rd_word;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule
